// File: rtl/serial_pattern_tx_if.sv
// Parallel-word handshake plus serial line outputs
// for the serial pattern transmitter.
interface serial_pattern_tx_if #(
    parameter int DATA_W = 8
);
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              data_out;
    logic              frame_active;
    logic              done;

    modport master (
        output in_valid,
        output in_data,
        input  in_ready,
        input  data_out,
        input  frame_active,
        input  done
    );

    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready,
        output data_out,
        output frame_active,
        output done
    );
endinterface

// File: rtl/serial_pattern_tx.sv
// Serial frame transmitter: preamble, payload MSB first, idle gap.
// All outputs registered from next-state values.
module serial_pattern_tx #(
    parameter int               DATA_W   = 8,
    parameter int               PRE_W    = 3,
    parameter logic [PRE_W-1:0] PREAMBLE = 3'b110,
    parameter int               GAP      = 2
) (
    input  logic               clk,
    input  logic               reset,
    serial_pattern_tx_if.slave bus
);
    localparam int M1   = (PRE_W > DATA_W) ? PRE_W : DATA_W;
    localparam int MAXC = (M1 > GAP) ? M1 : GAP;
    localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

    localparam logic [CW-1:0] PRE_LD = CW'(PRE_W - 1);
    localparam logic [CW-1:0] DAT_LD = CW'(DATA_W - 1);
    localparam logic [CW-1:0] GAP_LD = CW'((GAP > 0) ? GAP - 1 : 0);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PRE,
        S_DATA,
        S_GAP
    } state_t;

    state_t            state, state_n;
    logic [CW-1:0]     cnt, cnt_n;
    logic [DATA_W-1:0] sh, sh_n;
    logic [PRE_W-1:0]  pre_sh;
    logic              dout_n;
    logic              fa_n;
    logic              done_n;
    logic              rdy_n;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state            <= S_IDLE;
            cnt              <= '0;
            sh               <= '0;
            bus.data_out     <= 1'b0;
            bus.frame_active <= 1'b0;
            bus.done         <= 1'b0;
            bus.in_ready     <= 1'b1;
        end else begin
            state            <= state_n;
            cnt              <= cnt_n;
            sh               <= sh_n;
            bus.data_out     <= dout_n;
            bus.frame_active <= fa_n;
            bus.done         <= done_n;
            bus.in_ready     <= rdy_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        sh_n    = sh;
        unique case (state)
            S_IDLE: begin
                if (bus.in_valid && bus.in_ready) begin
                    sh_n    = bus.in_data;
                    cnt_n   = PRE_LD;
                    state_n = S_PRE;
                end
            end
            S_PRE: begin
                if (cnt == '0) begin
                    cnt_n   = DAT_LD;
                    state_n = S_DATA;
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
            S_DATA: begin
                sh_n = sh << 1;
                if (cnt == '0) begin
                    if (GAP > 0) begin
                        cnt_n   = GAP_LD;
                        state_n = S_GAP;
                    end else begin
                        state_n = S_IDLE;
                    end
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
            S_GAP: begin
                if (cnt == '0) begin
                    state_n = S_IDLE;
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
            default: begin
                state_n = S_IDLE;
                cnt_n   = '0;
                sh_n    = '0;
            end
        endcase
    end

    // Output decode looks at the upcoming state so the registers
    // present each state's bit during that state's own cycle.
    always_comb begin
        pre_sh = PREAMBLE >> cnt_n;
        dout_n = 1'b0;
        fa_n   = 1'b0;
        done_n = 1'b0;
        rdy_n  = 1'b0;
        unique case (1'b1)
            (state_n == S_IDLE): begin
                rdy_n = 1'b1;
            end
            (state_n == S_PRE): begin
                dout_n = pre_sh[0];
                fa_n   = 1'b1;
            end
            (state_n == S_DATA): begin
                dout_n = sh_n[DATA_W-1];
                fa_n   = 1'b1;
                done_n = (cnt_n == '0);
            end
            default: begin
                dout_n = 1'b0;
            end
        endcase
    end
endmodule

// File: tb/tb_serial_pattern_tx.sv
// Scoreboard bench for serial_pattern_tx: default instance
// plus a GAP=0 / DATA_W=4 / PRE_W=2 instance.
module tb_serial_pattern_tx;
    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    serial_pattern_tx_if #(.DATA_W(8)) a_if ();
    serial_pattern_tx_if #(.DATA_W(4)) b_if ();

    serial_pattern_tx dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (a_if)
    );

    serial_pattern_tx #(
        .DATA_W   (4),
        .PRE_W    (2),
        .PREAMBLE (2'b10),
        .GAP      (0)
    ) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (b_if)
    );

    // {data_out, frame_active, done, in_ready}
    typedef logic [3:0] obs_t;

    obs_t exp_q[$];
    int   acc_a[$];
    int   acc_b[$];
    int   passed = 0;
    int   failed = 0;
    int   total  = 0;
    int   cyc    = 0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!reset && a_if.in_valid && a_if.in_ready) acc_a.push_back(cyc);
        if (!reset && b_if.in_valid && b_if.in_ready) acc_b.push_back(cyc);
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog");
    end

    function automatic obs_t sample(bit alt);
        if (alt)
            return {b_if.data_out, b_if.frame_active, b_if.done, b_if.in_ready};
        return {a_if.data_out, a_if.frame_active, a_if.done, a_if.in_ready};
    endfunction

    task automatic check(string tag, int obs, int expv);
        total++;
        assert (obs === expv) passed++;
        else begin
            failed++;
            $error("FAIL %s: got %0h, want %0h", tag, obs, expv);
        end
    endtask

    task automatic push(bit d, bit fa, bit dn, bit rdy);
        exp_q.push_back({d, fa, dn, rdy});
    endtask

    task automatic push_frame(int pw, logic [7:0] pre, int dw,
                              logic [7:0] w, int gap);
        for (int i = pw - 1; i >= 0; i--) push(pre[i], 1'b1, 1'b0, 1'b0);
        for (int i = dw - 1; i >= 0; i--) push(w[i], 1'b1, i == 0, 1'b0);
        for (int i = 0; i < gap; i++) push(1'b0, 1'b0, 1'b0, 1'b0);
        push(1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic drain_one(bit alt, string tag, int k);
        obs_t e;
        @(negedge clk);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check($sformatf("%s[%0d]", tag, k), int'(sample(alt)), int'(e));
        end
    endtask

    task automatic drain_all(bit alt, string tag);
        int k = 0;
        while (exp_q.size() > 0) begin
            drain_one(alt, tag, k);
            k++;
        end
    endtask

    task automatic offer(bit alt, logic [7:0] w, bit hold);
        obs_t o;
        int   k = 0;
        @(negedge clk);
        o = sample(alt);
        while (!o[0] && k < 50) begin
            @(negedge clk);
            o = sample(alt);
            k++;
        end
        check($sformatf("ready_%0h", w), int'(o[0]), 1);
        if (alt) begin
            b_if.in_valid = 1'b1;
            b_if.in_data  = w[3:0];
        end else begin
            a_if.in_valid = 1'b1;
            a_if.in_data  = w;
        end
        @(posedge clk);
        #1;
        if (!hold) begin
            a_if.in_valid = 1'b0;
            b_if.in_valid = 1'b0;
        end
    endtask

    initial begin
        a_if.in_valid = 1'b0;
        a_if.in_data  = '0;
        b_if.in_valid = 1'b0;
        b_if.in_data  = '0;

        // asynchronous reset, checked before any clock edge
        #3 reset = 1'b1;
        #1;
        check("rst_a", int'(sample(1'b0)), 4'b0001);
        check("rst_b", int'(sample(1'b1)), 4'b0001);
        @(negedge clk);
        #2 reset = 1'b0;

        // single frame 0xA5
        push_frame(3, 8'b110, 8, 8'hA5, 2);
        offer(1'b0, 8'hA5, 1'b0);
        drain_all(1'b0, "single");

        // back-to-back 0xFF then 0x00, in_data churned mid-frame
        acc_a.delete();
        push_frame(3, 8'b110, 8, 8'hFF, 2);
        push_frame(3, 8'b110, 8, 8'h00, 2);
        offer(1'b0, 8'hFF, 1'b1);
        for (int k = 0; k < 13; k++) begin
            drain_one(1'b0, "b2b", k);
            a_if.in_data = (k < 12) ? 8'($urandom) : 8'h00;
        end
        drain_one(1'b0, "b2b", 13);
        @(posedge clk);
        #1 a_if.in_valid = 1'b0;
        drain_all(1'b0, "b2b2");
        check("b2b_acc_n", acc_a.size(), 2);
        if (acc_a.size() >= 2)
            check("b2b_acc_gap", acc_a[1] - acc_a[0], 14);

        // abort at the 3rd payload bit of 0xC3
        push_frame(3, 8'b110, 8, 8'hC3, 2);
        offer(1'b0, 8'hC3, 1'b0);
        for (int k = 0; k < 6; k++) drain_one(1'b0, "abort", k);
        #2 reset = 1'b1;
        #1;
        check("abort_out", int'(sample(1'b0)), 4'b0001);
        exp_q.delete();
        @(negedge clk);
        #2 reset = 1'b0;
        for (int k = 0; k < 3; k++) push(1'b0, 1'b0, 1'b0, 1'b1);
        drain_all(1'b0, "post_abort");

        // resume with 0x81
        push_frame(3, 8'b110, 8, 8'h81, 2);
        offer(1'b0, 8'h81, 1'b0);
        drain_all(1'b0, "resume");

        // alternate parameters: 0x9 then 0x6 held back-to-back
        acc_b.delete();
        push_frame(2, 8'b10, 4, 8'h09, 0);
        push_frame(2, 8'b10, 4, 8'h06, 0);
        offer(1'b1, 8'h09, 1'b1);
        for (int k = 0; k < 7; k++) begin
            drain_one(1'b1, "alt", k);
            b_if.in_data = 4'h6;
        end
        @(posedge clk);
        #1 b_if.in_valid = 1'b0;
        drain_all(1'b1, "alt2");
        check("alt_acc_n", acc_b.size(), 2);
        if (acc_b.size() >= 2)
            check("alt_acc_gap", acc_b[1] - acc_b[0], 7);

        // stall: no valid for 20 cycles
        for (int k = 0; k < 20; k++) push(1'b0, 1'b0, 1'b0, 1'b1);
        drain_all(1'b0, "stall");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/serial_pattern_tx.md
# serial_pattern_tx

Transmit-side counterpart of the serial sequence detector: accepts parallel words over a valid/ready handshake and emits each one on a single-bit serial line as a framed burst: fixed preamble, then payload MSB first, then a run of idle zeros. It sits at the stimulus/transmit end of the serial link and drives the `data_in` of the bit-serial detection logic. All outputs are registered.

## Interface
- `DATA_W`, default 8: payload bits per frame; legal range ≥ 1.
- `PRE_W`, default 3: preamble length in bits; legal range ≥ 1.
- `PREAMBLE`, default 3'b110: preamble pattern, `PRE_W` bits, sent MSB first.
- `GAP`, default 2: idle-zero cycles after the payload; legal range ≥ 0.
- `clk`: input, 1 bit, clock; all state is updated on its rising edge.
- `reset`: input, 1 bit, reset; asynchronous, active-high.
- `in_valid`: input, 1 bit, a word is offered on `in_data`.
- `in_data`: input, `DATA_W` bits, payload word.
- `in_ready`: output, 1 bit, the block can accept a word this cycle.
- `data_out`: output, 1 bit, serial line.
- `frame_active`: output, 1 bit, high while preamble or payload bits are on `data_out`.
- `done`: output, 1 bit, one-cycle pulse coincident with the last payload bit on `data_out`.

## Operation
- **FSM states:** IDLE, PRE, DATA, GAP. Counter `cnt` is sized to hold max(`PRE_W`, `DATA_W`, `GAP`) − 1. Payload shift register is `DATA_W` bits.
- **IDLE**
  - `in_ready` = 1, `data_out` = 0, `frame_active` = 0.
  - On `in_valid` && `in_ready`: latch `in_data` into the shift register, set `cnt` = `PRE_W` − 1, go to PRE.
- **PRE**
  - `data_out` = `PREAMBLE[cnt]`, `frame_active` = 1.
  - `cnt` decrements each cycle. When `cnt` == 0: set `cnt` = `DATA_W` − 1, go to DATA.
- **DATA**
  - `data_out` = shift register MSB, `frame_active` = 1. Shift left by one each cycle.
  - `done` = 1 in the cycle where `cnt` == 0.
  - At `cnt` == 0: if `GAP` > 0, set `cnt` = `GAP` − 1 and go to GAP; otherwise go to IDLE.
- **GAP**
  - `data_out` = 0, `frame_active` = 0, `in_ready` = 0.
  - Decrement `cnt`. At `cnt` == 0, go to IDLE.
- **Handshake**
  - `in_ready` is a registered decode of the IDLE state and is 0 in every other state.
  - `in_data` is sampled only on the accepting edge. Changes to `in_valid`/`in_data` outside IDLE are ignored.
  - A word that is offered is never dropped: `in_valid` may stay high indefinitely until it is accepted.
- **Outputs:** `data_out`, `frame_active` and `done` are registered, computed from next-state values, so each reflects the state of the current cycle with no combinational path from the inputs.
- **Reset:**
  - Asynchronous reset forces IDLE, `cnt` = 0, shift register = 0, `data_out` = 0, `frame_active` = 0, `done` = 0, `in_ready` = 1 (`in_ready` comes up as soon as IDLE is entered).
  - Reset mid-frame aborts the frame: no `done`, and no remaining bits are emitted.
- An undefined state encoding recovers to IDLE on the next edge.

## Timing
- **Latency:** if a word is accepted at edge N, the first preamble bit is on `data_out` from edge N to edge N+1.
- **Frame length:** `PRE_W` + `DATA_W` cycles of `frame_active` = 1, followed by `GAP` zero cycles, followed by at least 1 IDLE cycle (`data_out` = 0, `in_ready` = 1).
- **Maximum throughput:** one word per `PRE_W` + `DATA_W` + `GAP` + 1 cycles. With defaults this is 14 cycles.
- **`done` placement:** `done` rises on the same edge that presents payload bit 0 and falls one cycle later.
- **Boundary cases:**
  - With `GAP` = 0, DATA transitions directly to IDLE. The single IDLE cycle still separates frames.
  - With `DATA_W` = 1 or `PRE_W` = 1, the corresponding state lasts exactly 1 cycle.

## Test plan
- **Reset values:** assert `reset` asynchronously mid-cycle. Required: `data_out` = 0, `in_ready` = 1, `frame_active` = 0 and `done` = 0 immediately, before the next edge.
- **Single frame, default parameters:** offer `in_data` = 0xA5. Required `data_out` sequence from the accept edge: 1,1,0, 1,0,1,0,0,1,0,1, then 0,0 (gap), then 0 with `in_ready` = 1. `done` is high only on the 11th bit, and `frame_active` is high for exactly 11 cycles.
- **Back-to-back words:** hold `in_valid` high with 0xFF then 0x00. Required:
  - The second accept occurs exactly 14 cycles after the first.
  - Second frame bits are 1,1,0 followed by eight 0s.
  - `in_data` changes made while `in_ready` = 0 do not corrupt the first frame.
- **Abort and resume:** pulse `reset` at the 3rd payload bit of 0xC3. Required: `data_out` = 0 immediately and no `done`. A following word 0x81 is then accepted from IDLE and emits 1,1,0,1,0,0,0,0,0,0,1.
- **Alternate parameters:** `GAP` = 0, `DATA_W` = 4, `PRE_W` = 2, `PREAMBLE` = 2'b10, word 0x9. Required: emits 1,0,1,0,0,1, then exactly 1 IDLE cycle before the next accept.
- **Stall:** `in_valid` = 0 for 20 cycles. Required: `data_out` stays 0, `in_ready` stays 1, and `done` never asserts.
